// File: rtl/sap1_datapath.sv
// SAP-1 execution datapath: PC, MAR, RAM, IR, A, B, arithmetic unit and shared bus.
// Driven by the controller's 14-bit control word; reports opcode and status back.
module sap1_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter logic [DATA_W-1:0] DIV_ZERO_VAL = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [13:0]       ctrl,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              carry,
  output logic              halted,
  output logic              bus_conflict
);

  localparam int DIV_EN    = 13;
  localparam int MUL_EN    = 12;
  localparam int HLT       = 11;
  localparam int PC_INC    = 10;
  localparam int PC_EN     = 9;
  localparam int MEM_LOAD  = 8;
  localparam int MEM_EN    = 7;
  localparam int IR_LOAD   = 6;
  localparam int IR_EN     = 5;
  localparam int A_LOAD    = 4;
  localparam int A_EN      = 3;
  localparam int B_LOAD    = 2;
  localparam int ADDER_SUB = 1;
  localparam int ADDER_EN  = 0;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   bus;
  logic [6:0]          drivers;
  logic                conflict;
  logic                next_carry;

  always_comb begin
    if (ctrl[ADDER_SUB]) begin
      sum = {1'b0, a} - {1'b0, b};
    end else begin
      sum = {1'b0, a} + {1'b0, b};
    end
    // Borrow on subtract is simply A < B, independent of the wrapped difference.
    next_carry = ctrl[ADDER_SUB] ? (a < b) : sum[DATA_W];
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    quot = (b == '0) ? DIV_ZERO_VAL : a / b;
  end

  assign drivers = {ctrl[DIV_EN], ctrl[MUL_EN], ctrl[ADDER_EN], ctrl[A_EN],
                    ctrl[IR_EN], ctrl[MEM_EN], ctrl[PC_EN]};
  assign conflict = $countones(drivers) > 1;

  always_comb begin
    bus = '0;
    priority case (1'b1)
      ctrl[DIV_EN]:   bus = quot;
      ctrl[MUL_EN]:   bus = prod[DATA_W-1:0];
      ctrl[ADDER_EN]: bus = sum[DATA_W-1:0];
      ctrl[A_EN]:     bus = a;
      ctrl[IR_EN]:    bus = {{(DATA_W-4){1'b0}}, ir[3:0]};
      ctrl[MEM_EN]:   bus = mem[mar];
      ctrl[PC_EN]:    bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
      default:        bus = '0;
    endcase
  end

  // Program load stays open while halted so a stopped machine can be reloaded.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      mar          <= '0;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      carry        <= 1'b0;
      halted       <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      if (conflict) bus_conflict <= 1'b1;
      if (ctrl[HLT]) halted <= 1'b1;
      if (!halted) begin
        if (ctrl[PC_INC])   pc  <= pc + 1'b1;
        if (ctrl[MEM_LOAD]) mar <= bus[ADDR_W-1:0];
        if (ctrl[IR_LOAD])  ir  <= bus;
        if (ctrl[A_LOAD])   a   <= bus;
        if (ctrl[B_LOAD])   b   <= bus;
        if (ctrl[A_LOAD] && ctrl[ADDER_EN]) carry <= next_carry;
      end
    end
  end

  assign opcode  = ir[DATA_W-1:DATA_W-4];
  assign a_out   = a;
  assign bus_out = bus;

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed bench for sap1_datapath: reset, program run, arithmetic,
// PC wrap, bus conflict and halt freeze with hand-computed results.
module tb_sap1_datapath;

  localparam logic [13:0] DIV_EN    = 14'h2000;
  localparam logic [13:0] MUL_EN    = 14'h1000;
  localparam logic [13:0] HLT       = 14'h0800;
  localparam logic [13:0] PC_INC    = 14'h0400;
  localparam logic [13:0] PC_EN     = 14'h0200;
  localparam logic [13:0] MEM_LOAD  = 14'h0100;
  localparam logic [13:0] MEM_EN    = 14'h0080;
  localparam logic [13:0] IR_LOAD   = 14'h0040;
  localparam logic [13:0] IR_EN     = 14'h0020;
  localparam logic [13:0] A_LOAD    = 14'h0010;
  localparam logic [13:0] A_EN      = 14'h0008;
  localparam logic [13:0] B_LOAD    = 14'h0004;
  localparam logic [13:0] ADDER_SUB = 14'h0002;
  localparam logic [13:0] ADDER_EN  = 14'h0001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [13:0] ctrl = '0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [3:0] opcode;
  logic [7:0] a_out;
  logic [7:0] bus_out;
  logic       carry;
  logic       halted;
  logic       bus_conflict;

  int checks = 0;
  int errors = 0;

  sap1_datapath dut (
    .clk(clk),
    .rst(rst),
    .ctrl(ctrl),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .opcode(opcode),
    .a_out(a_out),
    .bus_out(bus_out),
    .carry(carry),
    .halted(halted),
    .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [13:0] c);
    ctrl = c;
    @(posedge clk);
    #1;
    ctrl = '0;
  endtask

  task automatic peek(input string tag, input logic [13:0] c,
                      input logic [7:0] exp);
    ctrl = c;
    #1;
    check(tag, 16'(bus_out), 16'(exp));
    ctrl = '0;
  endtask

  task automatic prog(input logic [3:0] ad, input logic [7:0] d);
    prog_we = 1'b1;
    prog_addr = ad;
    prog_data = d;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  task automatic reset();
    rst = 1'b1;
    tick('0);
    rst = 1'b0;
  endtask

  task automatic fetch();
    tick(PC_EN | MEM_LOAD);
    tick(PC_INC);
    tick(MEM_EN | IR_LOAD);
  endtask

  task automatic set_a(input logic [7:0] v);
    prog(4'd0, v);
    tick(MEM_EN | A_LOAD);
  endtask

  task automatic set_b(input logic [7:0] v);
    prog(4'd0, v);
    tick(MEM_EN | B_LOAD);
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset();

    prog(4'd0, 8'h3C);
    prog(4'd5, 8'h77);
    tick(MEM_EN | A_LOAD);
    check("preset_a", 16'(a_out), 16'h3C);
    tick(HLT);
    check("preset_halt", 16'(halted), 16'h1);
    reset();
    check("rst_a", 16'(a_out), 16'h00);
    check("rst_halt", 16'(halted), 16'h0);
    check("rst_carry", 16'(carry), 16'h0);
    check("rst_conf", 16'(bus_conflict), 16'h0);
    check("rst_op", 16'(opcode), 16'h0);
    peek("rst_pc", PC_EN, 8'h00);
    for (int i = 0; i < 5; i++) tick(PC_INC);
    tick(PC_EN | MEM_LOAD);
    peek("ram_kept", MEM_EN, 8'h77);

    reset();
    prog(4'd0, 8'h09);
    prog(4'd1, 8'h1A);
    prog(4'd2, 8'h3B);
    prog(4'd3, 8'hF0);
    prog(4'd9, 8'h05);
    prog(4'd10, 8'h03);
    prog(4'd11, 8'h04);

    fetch();
    check("op_lda", 16'(opcode), 16'h0);
    tick(IR_EN | MEM_LOAD);
    tick(MEM_EN | A_LOAD);
    tick('0);
    check("lda_a", 16'(a_out), 16'h05);

    fetch();
    check("op_add", 16'(opcode), 16'h1);
    tick(IR_EN | MEM_LOAD);
    tick(MEM_EN | B_LOAD);
    tick(ADDER_EN | A_LOAD);
    check("add_a", 16'(a_out), 16'h08);
    check("add_c", 16'(carry), 16'h0);

    fetch();
    check("op_mul", 16'(opcode), 16'h3);
    tick(IR_EN | MEM_LOAD);
    tick(MEM_EN | B_LOAD);
    tick(MUL_EN | A_LOAD);
    check("mul_a", 16'(a_out), 16'h20);

    fetch();
    check("op_hlt", 16'(opcode), 16'hF);
    check("pre_halt", 16'(halted), 16'h0);
    tick(HLT);
    check("halted", 16'(halted), 16'h1);
    peek("halt_pc", PC_EN, 8'h04);
    for (int i = 0; i < 3; i++) tick(PC_INC);
    peek("pc_frozen", PC_EN, 8'h04);
    tick(PC_EN | A_LOAD);
    check("a_frozen", 16'(a_out), 16'h20);
    prog(4'd3, 8'hAB);
    peek("halt_prog", MEM_EN, 8'hAB);
    check("op_held", 16'(opcode), 16'hF);

    reset();
    set_a(8'hF0);
    set_b(8'h20);
    tick(ADDER_EN | A_LOAD);
    check("add_wrap", 16'(a_out), 16'h10);
    check("add_carry", 16'(carry), 16'h1);
    set_a(8'h01);
    set_b(8'h02);
    tick(ADDER_EN | A_LOAD);
    check("add_small", 16'(a_out), 16'h03);
    check("add_nc", 16'(carry), 16'h0);
    set_a(8'h02);
    set_b(8'h05);
    tick(ADDER_EN | ADDER_SUB | A_LOAD);
    check("sub_a", 16'(a_out), 16'hFD);
    check("sub_borrow", 16'(carry), 16'h1);
    set_a(8'h10);
    set_b(8'h10);
    tick(MUL_EN | A_LOAD);
    check("mul_wrap", 16'(a_out), 16'h00);
    check("mul_c_hold", 16'(carry), 16'h1);
    set_a(8'h07);
    set_b(8'h00);
    tick(DIV_EN | A_LOAD);
    check("div_zero", 16'(a_out), 16'hFF);
    set_a(8'h64);
    set_b(8'h07);
    tick(DIV_EN | A_LOAD);
    check("div_a", 16'(a_out), 16'h0E);
    peek("prio_div", DIV_EN | MUL_EN | ADDER_EN, 8'h02);
    peek("prio_mul", MUL_EN | ADDER_EN | A_EN, 8'h62);
    peek("prio_add", ADDER_EN | A_EN | PC_EN, 8'h15);
    peek("none", '0, 8'h00);
    check("no_conf", 16'(bus_conflict), 16'h0);

    set_a(8'h11);
    prog(4'd0, 8'h22);
    peek("conf_bus", A_EN | MEM_EN, 8'h11);
    tick(A_EN | MEM_EN | B_LOAD);
    check("conf_set", 16'(bus_conflict), 16'h1);
    peek("conf_b", ADDER_EN, 8'h22);
    for (int i = 0; i < 10; i++) tick('0);
    check("conf_sticky", 16'(bus_conflict), 16'h1);
    tick(A_EN | A_LOAD);
    check("a_self", 16'(a_out), 16'h11);

    reset();
    prog(4'd6, 8'h66);
    for (int i = 0; i < 15; i++) tick(PC_INC);
    peek("pc15", PC_EN, 8'h0F);
    tick(PC_INC);
    peek("pc_wrap", PC_EN, 8'h00);
    for (int i = 0; i < 6; i++) tick(PC_INC);
    tick(PC_EN | PC_INC | MEM_LOAD);
    peek("pc_inc", PC_EN, 8'h07);
    peek("mar_old_pc", MEM_EN, 8'h66);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap1_datapath.md
Name: sap1_datapath

Overview:
- Execution datapath of the SAP-1 computer, driven by the 14-bit control word from the controller.
- Holds the program counter, memory address register (MAR), 16x8 RAM, instruction register (IR), accumulator A and register B.
- Contains the add/sub/mul/div unit and the shared 8-bit bus.
- Returns the current opcode to the controller; exposes A, halt and error status to the top level.

Parameters:
- DATA_W, 8, bus/register/RAM word width.
- ADDR_W, 4, PC/MAR width; RAM depth is 2**ADDR_W.
- DIV_ZERO_VAL, 8'hFF, quotient driven when B == 0 during DIV.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ctrl  in  14  control word. Bits: 13 DIV_EN, 12 MUL_EN, 11 HLT, 10 PC_INC, 9 PC_EN, 8 MEM_LOAD (MAR load), 7 MEM_EN, 6 IR_LOAD, 5 IR_EN, 4 A_LOAD, 3 A_EN, 2 B_LOAD, 1 ADDER_SUB, 0 ADDER_EN.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  ADDR_W  program-load address.
- prog_data  in  DATA_W  program-load data.
- opcode  out  4  IR[7:4], combinational from the IR register.
- a_out  out  DATA_W  accumulator contents.
- bus_out  out  DATA_W  current bus value (combinational).
- carry  out  1  registered carry/borrow of last adder result loaded into A.
- halted  out  1  sticky halt flag.
- bus_conflict  out  1  sticky error: more than one bus driver was asserted.

Behaviour:
- Reset (rst high at a clock edge): PC, MAR, IR, A, B = 0; carry, halted, bus_conflict = 0. RAM contents are not reset.
- Bus drivers (combinational):
  - PC_EN: {0, PC}
  - MEM_EN: RAM[MAR]
  - IR_EN: {0, IR[3:0]}
  - A_EN: A
  - ADDER_EN: A+B, or A-B when ADDER_SUB (mod 2**DATA_W)
  - MUL_EN: low DATA_W bits of A*B
  - DIV_EN: A/B truncated, or DIV_ZERO_VAL when B == 0
- No driver asserted: bus = 0.
- Multiple drivers asserted: priority DIV_EN > MUL_EN > ADDER_EN > A_EN > IR_EN > MEM_EN > PC_EN, and bus_conflict sets at that edge (stays set until reset).
- Loads: MEM_LOAD sets MAR <= bus[ADDR_W-1:0]; IR_LOAD sets IR <= bus; A_LOAD sets A <= bus; B_LOAD sets B <= bus. All take effect at the next rising edge, one cycle latency.
- A_LOAD together with A_EN is legal: A reloads its own value.
- PC_INC: PC <= PC+1, wrapping 15 -> 0. PC_INC together with PC_EN: the bus shows the old PC and PC increments.
- Carry: updated only when A_LOAD && ADDER_EN.
  - Add: carry = bit DATA_W of A+B.
  - Sub: carry = 1 when A < B (borrow).
  - Otherwise carry holds.
- HLT: at the edge where ctrl[11]=1, halted <= 1. While halted, PC, MAR, IR, A, B and carry are frozen and bus_conflict still updates. Only reset clears halted.
- Program load: prog_we writes RAM[prog_addr] <= prog_data at the edge. This is permitted even when halted.
- Same-cycle RAM write and read of the same address: MEM_EN drives the old data. The write is visible from the next cycle.
- Reset mid-instruction: all registers and flags return to reset values at that edge regardless of ctrl; RAM keeps its contents.
- opcode is held stable between IR loads.

Test Plan:
- Reset: set A=0x3C, halted=1, assert rst one cycle -> A=0, PC=0, halted=0, carry=0, bus_conflict=0, opcode=0; preloaded RAM[5]=0x77 still reads 0x77.
- Full program through the controller sequence: RAM[0]=0x09, [1]=0x1A, [2]=0x3B, [3]=0xF0, [9]=0x05, [10]=0x03, [11]=0x04 -> A=0x05, then 0x08, then 0x20; halted=1 after the 4th fetch; PC=4 and stays frozen.
- Arithmetic edges: A=0xF0, B=0x20, ADDER_EN|A_LOAD -> A=0x10, carry=1. A=0x02, B=0x05, SUB -> A=0xFD, carry=1. A=0x10, B=0x10, MUL -> A=0x00. A=0x07, B=0, DIV -> A=0xFF. A=0x64, B=0x07, DIV -> A=0x0E.
- PC wrap: PC=15, PC_INC -> PC=0. PC_EN|PC_INC|MEM_LOAD with PC=6 -> MAR=6, PC=7.
- Conflict: ctrl = A_EN|MEM_EN|B_LOAD with A=0x11, RAM[MAR]=0x22 -> B=0x11, bus_conflict=1, still 1 after ten idle cycles.
- Halt freeze: assert HLT, then ctrl=A_LOAD with bus from PC_EN -> A unchanged. prog_we writes RAM[3]=0xAB while halted -> MAR=3, MEM_EN reads 0xAB on bus_out.
